// File: rtl/cascade_ack_sequencer_if.sv
// rtl/cascade_ack_sequencer_if.sv - INTA#/CAS bus bundle between the PIC core and the cascade sequencer
interface cascade_ack_sequencer_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int ID_WIDTH     = 3
);
  logic [NUM_CHANNELS-1:0] acknowledge_interrupt;
  logic                    interrupt_acknowledge_n;
  logic [ID_WIDTH-1:0]     cascade_in;
  logic                    cascade_slave;
  logic [ID_WIDTH-1:0]     cascade_out;
  logic                    cascade_out_enable;
  logic                    cascade_slave_enable;
  logic [1:0]              ack_state;
  logic                    call_opcode_enable;
  logic                    send_vector_enable;
  logic                    end_of_ack_sequence;
  logic                    cascade_error;

  modport master (
    input  acknowledge_interrupt, interrupt_acknowledge_n, cascade_in,
    output cascade_slave, cascade_out, cascade_out_enable, cascade_slave_enable,
           ack_state, call_opcode_enable, send_vector_enable,
           end_of_ack_sequence, cascade_error
  );

  modport slave (
    output acknowledge_interrupt, interrupt_acknowledge_n, cascade_in,
    input  cascade_slave, cascade_out, cascade_out_enable, cascade_slave_enable,
           ack_state, call_opcode_enable, send_vector_enable,
           end_of_ack_sequence, cascade_error
  );
endinterface

// File: rtl/cascade_ack_sequencer.sv
// rtl/cascade_ack_sequencer.sv - 8259A cascade/INTA sequencer: CAS drive, slave select, data strobes, timeout
module cascade_ack_sequencer #(
  parameter int NUM_CHANNELS   = 8,
  parameter int ID_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    single_or_cascade_config,
  input  logic                    buffered_mode_config,
  input  logic                    buffered_master_or_slave_config,
  input  logic                    slave_program,
  input  logic                    x86_mode,
  input  logic [NUM_CHANNELS-1:0] cascade_device_config,
  cascade_ack_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2, ACK3 = 2'd3} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  state, state_d, final_state;
  logic                    inta_prev;
  logic [TW-1:0]           timer, timer_d;
  logic [NUM_CHANNELS-1:0] ack_vec, ack_vec_d;
  logic                    mode_x86, mode_x86_d;
  logic                    slave_en, slave_en_d;
  logic                    call_en, call_en_d;
  logic                    send_en, send_en_d;
  logic                    eoa, eoa_d;
  logic                    err, err_d;
  logic                    fall, rise, is_slave, slave_hit, hit_d, responder_d, drive_cas;
  logic [ID_WIDTH-1:0]     low_idx;

  assign fall     = inta_prev & ~bus.interrupt_acknowledge_n;
  assign rise     = ~inta_prev & bus.interrupt_acknowledge_n;
  assign is_slave = ~single_or_cascade_config &
                    (buffered_mode_config ? ~buffered_master_or_slave_config : ~slave_program);

  always_comb begin
    state_d     = state;
    ack_vec_d   = ack_vec;
    mode_x86_d  = mode_x86;
    slave_en_d  = slave_en;
    eoa_d       = 1'b0;
    err_d       = 1'b0;
    final_state = mode_x86 ? ACK2 : ACK3;

    if (fall || rise || state == IDLE) timer_d = '0;
    else                               timer_d = timer + 1'b1;

    case (state)
      IDLE: begin
        if (fall) begin
          state_d    = ACK1;
          ack_vec_d  = bus.acknowledge_interrupt;
          mode_x86_d = x86_mode;
        end
      end
      default: begin
        // A fall in the final state is ignored; only its rise completes the sequence.
        if (fall && state != final_state) begin
          state_d = state_t'(state + 2'd1);
        end else if (rise && state == final_state) begin
          state_d = IDLE;
          eoa_d   = 1'b1;
        end else if (!fall && !rise && timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
        if (rise && state == ACK1)
          slave_en_d = is_slave & (bus.cascade_in == cascade_device_config[ID_WIDTH-1:0]);
      end
    endcase

    if (state_d == IDLE) slave_en_d = 1'b0;

    // Strobes are computed from next-state values so they line up with the state they belong to.
    hit_d       = |(ack_vec_d & cascade_device_config);
    responder_d = single_or_cascade_config | (~is_slave & ~hit_d) | (is_slave & slave_en_d);
    call_en_d   = responder_d & ~mode_x86_d & ~is_slave & ~bus.interrupt_acknowledge_n &
                  (state_d == ACK1);
    send_en_d   = responder_d & ~bus.interrupt_acknowledge_n &
                  ((state_d == ACK2) | (~mode_x86_d & (state_d == ACK3)));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      inta_prev <= 1'b1;
      timer     <= '0;
      ack_vec   <= '0;
      mode_x86  <= 1'b0;
      slave_en  <= 1'b0;
      call_en   <= 1'b0;
      send_en   <= 1'b0;
      eoa       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      inta_prev <= bus.interrupt_acknowledge_n;
      timer     <= timer_d;
      ack_vec   <= ack_vec_d;
      mode_x86  <= mode_x86_d;
      slave_en  <= slave_en_d;
      call_en   <= call_en_d;
      send_en   <= send_en_d;
      eoa       <= eoa_d;
      err       <= err_d;
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (ack_vec[i]) low_idx = ID_WIDTH'(i);
  end

  assign slave_hit = |(ack_vec & cascade_device_config);
  assign drive_cas = (state != IDLE) & ~is_slave & ~single_or_cascade_config & slave_hit;

  assign bus.cascade_slave        = is_slave;
  assign bus.cascade_out          = drive_cas ? low_idx : '0;
  assign bus.cascade_out_enable   = drive_cas;
  assign bus.cascade_slave_enable = slave_en;
  assign bus.ack_state            = state;
  assign bus.call_opcode_enable   = call_en;
  assign bus.send_vector_enable   = send_en;
  assign bus.end_of_ack_sequence  = eoa;
  assign bus.cascade_error        = err;
endmodule

// File: tb/tb_cascade_ack_sequencer.sv
// tb/tb_cascade_ack_sequencer.sv - table-driven bench for cascade_ack_sequencer
module tb_cascade_ack_sequencer;
  localparam int NC = 8;
  localparam int IW = 3;
  localparam int TO = 20;

  typedef struct {
    logic       sngl, bufm, ms, sp, x86;
    logic [7:0] icw3, ack;
    logic [2:0] cas;
    int         pulses;
    logic       exp_slave, exp_coe, exp_cse;
    logic [2:0] exp_cout, call_mask, send_mask;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  logic sngl, bufm, ms, sp, x86;
  logic [NC-1:0] icw3;
  int tests = 0;
  int failures = 0;
  vec_t vecs[11];

  cascade_ack_sequencer_if #(.NUM_CHANNELS(NC), .ID_WIDTH(IW)) bus ();

  cascade_ack_sequencer #(.NUM_CHANNELS(NC), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .single_or_cascade_config        (sngl),
    .buffered_mode_config            (bufm),
    .buffered_master_or_slave_config (ms),
    .slave_program                   (sp),
    .x86_mode                        (x86),
    .cascade_device_config           (icw3),
    .bus                             (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic s, logic b, logic m, logic p, logic x, logic [7:0] i3,
                              logic [7:0] a, logic [2:0] c, int n, logic es, logic ecoe,
                              logic ecse, logic [2:0] ecout, logic [2:0] cm, logic [2:0] sm);
    vec_t v;
    v.sngl = s; v.bufm = b; v.ms = m; v.sp = p; v.x86 = x; v.icw3 = i3; v.ack = a; v.cas = c;
    v.pulses = n; v.exp_slave = es; v.exp_coe = ecoe; v.exp_cse = ecse; v.exp_cout = ecout;
    v.call_mask = cm; v.send_mask = sm;
    return v;
  endfunction

  task automatic set_cfg(input logic s, input logic b, input logic m, input logic p,
                         input logic x, input logic [7:0] i3, input logic [7:0] a,
                         input logic [2:0] c);
    sngl = s; bufm = b; ms = m; sp = p; x86 = x; icw3 = i3;
    bus.acknowledge_interrupt = a;
    bus.cascade_in = c;
  endtask

  initial begin
    int   eoa_cnt;
    logic ok;
    string tag;

    //        sngl buf ms sp x86 icw3   ack    cas  n  slv coe cse cout call    send
    vecs[0]  = mk(1, 0, 0, 1, 1, 8'h00, 8'h04, 3'd0, 2, 0, 0, 0, 3'd0, 3'b000, 3'b010);
    vecs[1]  = mk(0, 0, 0, 1, 0, 8'h08, 8'h08, 3'd0, 3, 0, 1, 0, 3'd3, 3'b000, 3'b000);
    vecs[2]  = mk(0, 0, 0, 1, 0, 8'h08, 8'h20, 3'd0, 3, 0, 0, 0, 3'd0, 3'b001, 3'b110);
    vecs[3]  = mk(0, 0, 0, 0, 1, 8'h02, 8'h01, 3'd2, 2, 1, 0, 1, 3'd0, 3'b000, 3'b010);
    vecs[4]  = mk(0, 0, 0, 0, 1, 8'h02, 8'h01, 3'd5, 2, 1, 0, 0, 3'd0, 3'b000, 3'b000);
    vecs[5]  = mk(0, 1, 1, 0, 1, 8'h00, 8'h01, 3'd0, 2, 0, 0, 0, 3'd0, 3'b000, 3'b010);
    vecs[6]  = mk(0, 1, 0, 1, 0, 8'h05, 8'h00, 3'd5, 3, 1, 0, 1, 3'd0, 3'b000, 3'b110);
    vecs[7]  = mk(0, 0, 0, 1, 0, 8'hFF, 8'h00, 3'd0, 3, 0, 0, 0, 3'd0, 3'b001, 3'b110);
    vecs[8]  = mk(0, 0, 0, 1, 1, 8'h40, 8'h60, 3'd0, 2, 0, 1, 0, 3'd5, 3'b000, 3'b000);
    vecs[9]  = mk(1, 0, 0, 1, 0, 8'h04, 8'h04, 3'd0, 3, 0, 0, 0, 3'd0, 3'b001, 3'b110);
    vecs[10] = mk(0, 1, 0, 1, 1, 8'h06, 8'h01, 3'd6, 2, 1, 0, 1, 3'd0, 3'b000, 3'b010);

    reset_n = 1'b0;
    set_cfg(1, 0, 0, 1, 1, 8'h00, 8'h00, 3'd0);
    bus.interrupt_acknowledge_n = 1'b1;
    repeat (3) tick();
    check("reset state", 8'(bus.ack_state), 8'd0);
    check("reset strobes", 8'({bus.call_opcode_enable, bus.send_vector_enable}), 8'd0);
    check("reset pulses", 8'({bus.end_of_ack_sequence, bus.cascade_error}), 8'd0);
    check("reset cas", 8'({bus.cascade_out_enable, bus.cascade_out, bus.cascade_slave_enable}), 8'd0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      set_cfg(vecs[v].sngl, vecs[v].bufm, vecs[v].ms, vecs[v].sp, vecs[v].x86,
              vecs[v].icw3, vecs[v].ack, vecs[v].cas);
      bus.interrupt_acknowledge_n = 1'b1;
      tick(); tick();
      tag = $sformatf("vec%0d", v);
      check({tag, " role"}, 8'(bus.cascade_slave), 8'(vecs[v].exp_slave));
      check({tag, " idle state"}, 8'(bus.ack_state), 8'd0);
      eoa_cnt = 0;
      for (int p = 1; p <= vecs[v].pulses; p++) begin
        bus.interrupt_acknowledge_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
          tick();
          check($sformatf("%s p%0d low state", tag, p), 8'(bus.ack_state), 8'(p));
          check($sformatf("%s p%0d call", tag, p), 8'(bus.call_opcode_enable), 8'(vecs[v].call_mask[p-1]));
          check($sformatf("%s p%0d send", tag, p), 8'(bus.send_vector_enable), 8'(vecs[v].send_mask[p-1]));
          check($sformatf("%s p%0d coe", tag, p), 8'(bus.cascade_out_enable), 8'(vecs[v].exp_coe));
          check($sformatf("%s p%0d cout", tag, p), 8'(bus.cascade_out), 8'(vecs[v].exp_cout));
          check($sformatf("%s p%0d cse", tag, p), 8'(bus.cascade_slave_enable),
                8'((p > 1) ? vecs[v].exp_cse : 1'b0));
          check($sformatf("%s p%0d err", tag, p), 8'(bus.cascade_error), 8'd0);
          eoa_cnt += int'(bus.end_of_ack_sequence);
        end
        bus.interrupt_acknowledge_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
          tick();
          check($sformatf("%s p%0d high state", tag, p), 8'(bus.ack_state),
                8'((p == vecs[v].pulses) ? 0 : p));
          check($sformatf("%s p%0d high strobes", tag, p),
                8'({bus.call_opcode_enable, bus.send_vector_enable}), 8'd0);
          check($sformatf("%s p%0d high coe", tag, p), 8'(bus.cascade_out_enable),
                8'((p == vecs[v].pulses) ? 1'b0 : vecs[v].exp_coe));
          check($sformatf("%s p%0d high cse", tag, p), 8'(bus.cascade_slave_enable),
                8'((p == vecs[v].pulses) ? 1'b0 : vecs[v].exp_cse));
          check($sformatf("%s p%0d eoa", tag, p), 8'(bus.end_of_ack_sequence),
                8'((p == vecs[v].pulses) && (c == 0)));
          check($sformatf("%s p%0d high err", tag, p), 8'(bus.cascade_error), 8'd0);
          eoa_cnt += int'(bus.end_of_ack_sequence);
        end
      end
      check({tag, " eoa count"}, 8'(eoa_cnt), 8'd1);
    end

    // Timeout: one pulse, then INTA# parked high.
    set_cfg(1, 0, 0, 1, 1, 8'h00, 8'h04, 3'd0);
    bus.interrupt_acknowledge_n = 1'b0;
    repeat (4) tick();
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    check("to after rise state", 8'(bus.ack_state), 8'd1);
    ok = 1'b1;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (bus.ack_state != 2'd1 || bus.cascade_error || bus.end_of_ack_sequence) ok = 1'b0;
    end
    check("to wait window", 8'(ok), 8'd1);
    tick();
    check("to error pulse", 8'(bus.cascade_error), 8'd1);
    check("to state idle", 8'(bus.ack_state), 8'd0);
    check("to no eoa", 8'(bus.end_of_ack_sequence), 8'd0);
    tick();
    check("to error one cycle", 8'(bus.cascade_error), 8'd0);
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    check("to fresh ack1", 8'(bus.ack_state), 8'd1);
    check("to fresh no send", 8'(bus.send_vector_enable), 8'd0);
    repeat (3) tick();
    bus.interrupt_acknowledge_n = 1'b1;
    repeat (3) tick();
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    check("to fresh ack2", 8'(bus.ack_state), 8'd2);
    check("to fresh send", 8'(bus.send_vector_enable), 8'd1);
    repeat (3) tick();
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    check("to fresh eoa", 8'(bus.end_of_ack_sequence), 8'd1);
    check("to fresh idle", 8'(bus.ack_state), 8'd0);
    repeat (3) tick();

    // Reset in the middle of ACK2 with the master driving CAS.
    set_cfg(0, 0, 0, 1, 1, 8'h08, 8'h08, 3'd0);
    bus.interrupt_acknowledge_n = 1'b0;
    repeat (4) tick();
    bus.interrupt_acknowledge_n = 1'b1;
    repeat (4) tick();
    bus.interrupt_acknowledge_n = 1'b0;
    repeat (2) tick();
    check("rst pre state", 8'(bus.ack_state), 8'd2);
    check("rst pre coe", 8'(bus.cascade_out_enable), 8'd1);
    reset_n = 1'b0;
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    check("rst state", 8'(bus.ack_state), 8'd0);
    check("rst cas", 8'({bus.cascade_out_enable, bus.cascade_out, bus.cascade_slave_enable}), 8'd0);
    check("rst strobes", 8'({bus.call_opcode_enable, bus.send_vector_enable}), 8'd0);
    check("rst pulses", 8'({bus.end_of_ack_sequence, bus.cascade_error}), 8'd0);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.ack_state != 2'd0 || bus.end_of_ack_sequence || bus.cascade_error) ok = 1'b0;
    end
    check("rst silent after", 8'(ok), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/cascade_ack_sequencer.md
Name: cascade_ack_sequencer

Overview:
- Parametrised, clocked cascade controller for the 8259A-compatible PIC.
- Tracks the INTA pulse sequence: 2 pulses in x86 mode, 3 pulses in 8080/85 mode.
- Master role: latches and drives the slave ID on CAS. Slave role: samples CAS and decides whether to respond.
- Issues data-bus drive strobes to the data-bus buffer and recovers from a stalled sequence by timeout.

Parameters:
- NUM_CHANNELS, 8, number of IR inputs / possible slaves (power of two, 2..8).
- ID_WIDTH, 3, CAS bus width; must equal log2(NUM_CHANNELS).
- TIMEOUT_CYCLES, 255, clocks waited for the next INTA edge before aborting (≥2).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- single_or_cascade_config  in  1  ICW1 SNGL; 1 = single mode.
- buffered_mode_config  in  1  ICW4 BUF.
- buffered_master_or_slave_config  in  1  ICW4 M/S; 1 = master (used when BUF=1).
- slave_program  in  1  SP/EN pin level; 1 = master (used when BUF=0).
- x86_mode  in  1  ICW4 µPM; 1 = 2-pulse sequence.
- cascade_device_config  in  NUM_CHANNELS  ICW3. Master: IR bits with a slave attached. Slave: [ID_WIDTH-1:0] = own ID.
- acknowledge_interrupt  in  NUM_CHANNELS  one-hot IR granted by the priority resolver; valid at the first INTA fall.
- interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock.
- cascade_in  in  ID_WIDTH  CAS lines as received.
- cascade_slave  out  1  1 = this device is a slave (combinational from config).
- cascade_out  out  ID_WIDTH  slave ID driven by the master.
- cascade_out_enable  out  1  CAS tristate enable.
- cascade_slave_enable  out  1  registered; this slave was addressed.
- ack_state  out  2  0 IDLE, 1 ACK1, 2 ACK2, 3 ACK3.
- call_opcode_enable  out  1  drive CALL opcode (8080 mode, first pulse).
- send_vector_enable  out  1  drive vector/address byte.
- end_of_ack_sequence  out  1  one-cycle pulse at sequence completion.
- cascade_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- **Reset.** reset_n=0 at a rising edge gives: state IDLE; all registered outputs 0; latches, timeout counter and edge-detect register cleared; edge-detect prev = 1. Reset mid-sequence aborts silently, with no end or error pulse.
- **Role decode (combinational).**
  - cascade_slave = 0 if SNGL = 1.
  - Otherwise cascade_slave = ~slave_program when BUF = 0, else ~buffered_master_or_slave_config.
- **Edge detection.** Register previous INTA#. fall = prev & ~now; rise = ~prev & now.
- **FSM.**
  - IDLE → ACK1 on fall. On that edge, latch ack_vec ← acknowledge_interrupt and mode_x86 ← x86_mode.
  - ACKn → ACK(n+1) on the next fall.
  - The final state is ACK2 if mode_x86, else ACK3. A rise in the final state → IDLE, with end_of_ack_sequence=1 for one cycle.
  - A fall while in the final state is ignored.
- **Timeout.** Counter clears on every edge and counts while state ≠ IDLE. On reaching TIMEOUT_CYCLES-1: state → IDLE, cascade_error=1 for one cycle, all drive outputs drop the same cycle.
- **Master, slave-serviced case.**
  - slave_hit = |(ack_vec & cascade_device_config).
  - cascade_out = index of the lowest set bit of ack_vec.
  - cascade_out_enable=1 from the cycle after ACK1 entry until IDLE, only when cascade_slave=0, SNGL=0 and slave_hit=1.
  - Otherwise cascade_out=0 and cascade_out_enable=0.
  - ack_vec = 0 (spurious) gives slave_hit=0.
- **Slave.**
  - cascade_in is sampled on the rise ending ACK1.
  - cascade_slave_enable ← (cascade_in == cascade_device_config[ID_WIDTH-1:0]).
  - Held until IDLE; cleared on return to IDLE.
- **responder** = SNGL | (master & ~slave_hit) | (slave & cascade_slave_enable).
- **Drive strobes** (registered, asserted the cycle after the fall, deasserted the cycle after the rise):
  - call_opcode_enable = responder & ~mode_x86 & ~cascade_slave & INTA# low in ACK1.
  - send_vector_enable = responder & INTA# low in ACK2 (x86), or in ACK2/ACK3 (8080).
- **Config stability.** Config changes mid-sequence affect only the combinational role decode; mode_x86 and ack_vec stay latched.

Test Plan:
- **Single, x86.** SNGL=1, x86=1, ack=0x04, two INTA# pulses (4 clk low, 4 high) → state 0→1→2→0; send_vector_enable high only during the second low; end pulse once; cascade_out_enable=0.
- **Master, slave on IR3, 8080.** SP=1, ICW3=0x08, ack=0x08, three pulses → cascade_out=3 with cascade_out_enable=1 from ACK1 until IDLE; call_opcode_enable=0; send_vector_enable=0.
- **Master, 8080, unslaved IR5.** ICW3=0x08, ack=0x20 → call_opcode_enable during pulse 1; send_vector_enable during pulses 2 and 3; cascade_out_enable=0.
- **Slave, ID=2, x86.** SP=0, cascade_in=2 → cascade_slave_enable=1 after the first rise; vector strobe in ACK2. Repeat with cascade_in=5 → no strobes, sequence still ends.
- **Timeout.** One INTA# pulse, then held high for TIMEOUT_CYCLES → cascade_error pulse, state IDLE, no end pulse; the next fall starts a fresh ACK1.
- **Reset mid-ACK2.** Assert reset_n=0 for one clock → all outputs 0 the next cycle, no end/error pulse.
